// File: rtl/pdp_pkg.sv
// Shared definitions for the pseudo-dual-port RAM burst reader.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package pdp_pkg;

  // Width of the saturating ECC event counters.
  localparam int SAT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // RAM read latency in cycles: the output register adds one.
  function automatic int rd_latency(input string regmode);
    return (regmode == "reg") ? 2 : 1;
  endfunction

endpackage

// File: rtl/pdp_rd_fifo.sv
// Synchronous return-data FIFO with occupancy count; any depth >= 2.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the producer must only push when room exists.
// Ports: rd_clk_i/rst_i (async, active-high) clock and reset; push_vld/push_dat
// write side; pop_rdy pops the head when head_vld; head_dat is 0 when empty;
// count is the current occupancy.
module pdp_rd_fifo import pdp_pkg::*; #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             rd_clk_i,
  input  logic             rst_i,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;

  assign head_vld = (cnt != '0);
  assign do_pop   = pop_rdy & head_vld;
  // Gate the head so an empty FIFO presents zero rather than stale storage.
  assign head_dat = head_vld ? mem[rd_ptr] : '0;
  assign count    = cnt;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  always_ff @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      // Push and pop together (including when full) leave the count unchanged.
      case ({push_vld, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge rd_clk_i) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/pdp_burst_reader.sv
// Burst read engine for the PDP RAM read port with a credit-protected return buffer.
// Latency: first beat LAT+1 cycles after the accept edge (LAT = 2 "reg", 1 "noreg"); then 1 beat/cycle.
// Backpressure: dout_ready_i low stalls reads once in-flight + buffered beats reach FIFO_DEPTH; no beat is lost.
// Ports: req_* burst request (addr, beats-1); rd_* RAM read port and clock enables;
// rd_data_i RAM data; dout_* return stream with last flag; busy_o burst in progress.
// Optional macro PDP_BURST_READER_ECC_STATUS_EN carries one/two-bit ECC flags with
// each beat (dout_err1_o/dout_err2_o) and counts popped flagged beats (ecc_*_cnt_o).
module pdp_burst_reader import pdp_pkg::*; #(
  parameter int    RADDR_DEPTH = 1024,
  parameter int    RADDR_WIDTH = clog2(RADDR_DEPTH),
  parameter int    RDATA_WIDTH = 18,
  parameter string REGMODE     = "reg",
  parameter int    LEN_WIDTH   = 8,
  parameter int    FIFO_DEPTH  = 4
) (
  input  logic                   rd_clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [RADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]   req_len_i,
  output logic                   rd_en_o,
  output logic [RADDR_WIDTH-1:0] rd_addr_o,
  output logic                   rd_clk_en_o,
  output logic                   rd_out_clk_en_o,
  input  logic [RDATA_WIDTH-1:0] rd_data_i,
  input  logic                   one_err_det_i,
  input  logic                   two_err_det_i,
  output logic                   dout_valid_o,
  output logic [RDATA_WIDTH-1:0] dout_data_o,
  output logic                   dout_last_o,
  input  logic                   dout_ready_i,
  output logic                   busy_o
`ifdef PDP_BURST_READER_ECC_STATUS_EN
  ,
  output logic                   dout_err1_o,
  output logic                   dout_err2_o,
  output logic [SAT_CNT_W-1:0]   ecc_one_cnt_o,
  output logic [SAT_CNT_W-1:0]   ecc_two_cnt_o
`endif
);

  localparam int LAT = rd_latency(REGMODE);
  localparam int CW  = clog2(FIFO_DEPTH + 1);
`ifdef PDP_BURST_READER_ECC_STATUS_EN
  localparam int FW  = RDATA_WIDTH + 3;
`else
  localparam int FW  = RDATA_WIDTH + 1;
`endif

  if (FIFO_DEPTH < LAT + 1) begin : g_bad_depth
    $error("pdp_burst_reader: FIFO_DEPTH must be at least read latency + 1");
  end

  rd_state_e            state_q, state_d;
  logic                 run_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [LAT-1:0]       pipe_vld_q;
  logic [LAT-1:0]       pipe_last_q;
  logic [CW-1:0]        fifo_cnt;
  logic [FW-1:0]        push_dat;
  logic [FW-1:0]        head_dat;
  logic                 head_vld;
  logic                 push;
  logic                 pop;
  logic                 issue;
  logic                 credit;
  logic                 accept;
  int                   in_flight;

  assign accept    = req_valid_i & req_ready_o;
  assign in_flight = $countones(pipe_vld_q);
  // Every outstanding read already owns a FIFO slot, so pushes can never overflow.
  assign credit    = (in_flight + int'(fifo_cnt)) < FIFO_DEPTH;

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        // run_q keeps ready low while reset is held and for the release edge.
        req_ready_o = run_q;
        if (req_valid_i && run_q) state_d = ISSUE;
      end
      ISSUE: begin
        issue = credit;
        if (credit && rem_q == '0) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && dout_last_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_ff @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_addr_o <= '0;
      rem_q     <= '0;
    end else if (accept) begin
      rd_addr_o <= req_addr_i;
      rem_q     <= req_len_i;
    end else if (issue) begin
      rd_addr_o <= (rd_addr_o == RADDR_WIDTH'(RADDR_DEPTH - 1)) ? '0 : rd_addr_o + RADDR_WIDTH'(1);
      if (rem_q != '0) rem_q <= rem_q - LEN_WIDTH'(1);
    end
  end

  // Latency pipe: stage LAT-1 lines up with the RAM data for that read.
  always_ff @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_last_q[0] <= issue & (rem_q == '0);
      for (int i = 1; i < LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  assign rd_en_o         = issue;
  assign rd_out_clk_en_o = issue | pipe_vld_q[0];
  assign rd_clk_en_o     = (LAT == 2) ? rd_out_clk_en_o : issue;
  assign busy_o          = (state_q != IDLE);

  assign push = pipe_vld_q[LAT-1];
  assign pop  = head_vld & dout_ready_i;

`ifdef PDP_BURST_READER_ECC_STATUS_EN
  assign push_dat = {two_err_det_i, one_err_det_i, pipe_last_q[LAT-1], rd_data_i};
`else
  assign push_dat = {pipe_last_q[LAT-1], rd_data_i};
  logic unused_ecc;
  assign unused_ecc = one_err_det_i ^ two_err_det_i;
`endif

  pdp_rd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .rd_clk_i (rd_clk_i),
    .rst_i    (rst_i),
    .push_vld (push),
    .push_dat (push_dat),
    .pop_rdy  (dout_ready_i),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (fifo_cnt)
  );

  assign dout_valid_o = head_vld;
  assign dout_data_o  = head_dat[RDATA_WIDTH-1:0];
  assign dout_last_o  = head_dat[RDATA_WIDTH];

`ifdef PDP_BURST_READER_ECC_STATUS_EN
  assign dout_err1_o = head_dat[RDATA_WIDTH+1];
  assign dout_err2_o = head_dat[RDATA_WIDTH+2];

  // Counts only beats actually handed to the consumer.
  always_ff @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      ecc_one_cnt_o <= '0;
      ecc_two_cnt_o <= '0;
    end else if (pop) begin
      if (dout_err1_o && ecc_one_cnt_o != '1) ecc_one_cnt_o <= ecc_one_cnt_o + SAT_CNT_W'(1);
      if (dout_err2_o && ecc_two_cnt_o != '1) ecc_two_cnt_o <= ecc_two_cnt_o + SAT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pdp_burst_reader.sv
// Bench for pdp_burst_reader: one registered-output instance (depth 1000) and one
// unregistered-output instance (depth 1024), each with a behavioural RAM holding mem[i]=i.
module tb_pdp_burst_reader;
  localparam int AW = 10;
  localparam int DW = 18;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [DW-1:0] mem [1024];
  int   ecc1_addr = -1;

  always #5 clk = ~clk;

  // Instance A: REGMODE "reg", RADDR_DEPTH 1000
  logic a_req_vld, a_req_rdy, a_rd_en, a_rd_ce, a_rd_oce, a_one, a_two;
  logic a_dv, a_dl, a_dr, a_busy;
  logic [AW-1:0] a_req_addr, a_rd_addr;
  logic [LW-1:0] a_req_len;
  logic [DW-1:0] a_rd_data, a_dd;
  logic [DW-1:0] a_q1 = '0;
  logic [DW-1:0] a_q2 = '0;
  logic a_f1 = 1'b0;
  logic a_f2 = 1'b0;
`ifdef PDP_BURST_READER_ECC_STATUS_EN
  logic a_e1, a_e2;
  logic [15:0] a_c1, a_c2;
`endif

  pdp_burst_reader #(
    .RADDR_DEPTH(1000), .RADDR_WIDTH(AW), .RDATA_WIDTH(DW),
    .REGMODE("reg"), .LEN_WIDTH(LW), .FIFO_DEPTH(4)
  ) u_a (
    .rd_clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_vld), .req_ready_o(a_req_rdy),
    .req_addr_i(a_req_addr), .req_len_i(a_req_len),
    .rd_en_o(a_rd_en), .rd_addr_o(a_rd_addr),
    .rd_clk_en_o(a_rd_ce), .rd_out_clk_en_o(a_rd_oce),
    .rd_data_i(a_rd_data), .one_err_det_i(a_one), .two_err_det_i(a_two),
    .dout_valid_o(a_dv), .dout_data_o(a_dd), .dout_last_o(a_dl),
    .dout_ready_i(a_dr), .busy_o(a_busy)
`ifdef PDP_BURST_READER_ECC_STATUS_EN
    , .dout_err1_o(a_e1), .dout_err2_o(a_e2),
    .ecc_one_cnt_o(a_c1), .ecc_two_cnt_o(a_c2)
`endif
  );

  // Registered-output RAM model; the ECC flag travels with the data.
  always @(posedge clk) begin
    if (a_rd_ce && a_rd_en) begin
      a_q1 <= mem[a_rd_addr];
      a_f1 <= (int'(a_rd_addr) == ecc1_addr);
    end
    if (a_rd_oce) begin
      a_q2 <= a_q1;
      a_f2 <= a_f1;
    end
  end
  assign a_rd_data = a_q2;
  assign a_one     = a_f2;
  assign a_two     = 1'b0;

  // Instance B: REGMODE "noreg", RADDR_DEPTH 1024
  logic b_req_vld, b_req_rdy, b_rd_en, b_rd_ce, b_rd_oce;
  logic b_dv, b_dl, b_dr, b_busy;
  logic [AW-1:0] b_req_addr, b_rd_addr;
  logic [LW-1:0] b_req_len;
  logic [DW-1:0] b_rd_data, b_dd;
  logic [DW-1:0] b_q1 = '0;
`ifdef PDP_BURST_READER_ECC_STATUS_EN
  logic b_e1, b_e2;
  logic [15:0] b_c1, b_c2;
`endif

  pdp_burst_reader #(
    .RADDR_DEPTH(1024), .RADDR_WIDTH(AW), .RDATA_WIDTH(DW),
    .REGMODE("noreg"), .LEN_WIDTH(LW), .FIFO_DEPTH(4)
  ) u_b (
    .rd_clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_vld), .req_ready_o(b_req_rdy),
    .req_addr_i(b_req_addr), .req_len_i(b_req_len),
    .rd_en_o(b_rd_en), .rd_addr_o(b_rd_addr),
    .rd_clk_en_o(b_rd_ce), .rd_out_clk_en_o(b_rd_oce),
    .rd_data_i(b_rd_data), .one_err_det_i(1'b0), .two_err_det_i(1'b0),
    .dout_valid_o(b_dv), .dout_data_o(b_dd), .dout_last_o(b_dl),
    .dout_ready_i(b_dr), .busy_o(b_busy)
`ifdef PDP_BURST_READER_ECC_STATUS_EN
    , .dout_err1_o(b_e1), .dout_err2_o(b_e2),
    .ecc_one_cnt_o(b_c1), .ecc_two_cnt_o(b_c2)
`endif
  );

  always @(posedge clk) begin
    if (b_rd_ce && b_rd_en) b_q1 <= mem[b_rd_addr];
  end
  assign b_rd_data = b_q1;

  // Present a request on A at a negedge; returns at the negedge after the accept edge.
  task automatic req_a(input int addr, input int len);
    a_req_addr = AW'(addr);
    a_req_len  = LW'(len);
    a_req_vld  = 1'b1;
    @(negedge clk);
    a_req_vld  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({a_req_rdy, a_rd_en, a_rd_ce, a_rd_oce, a_dv, a_dl, a_busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl_a: got %b want 0000000",
               {a_req_rdy, a_rd_en, a_rd_ce, a_rd_oce, a_dv, a_dl, a_busy});
    end
    checks++;
    if (a_dd !== '0 || a_rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_data_a: data %0d addr %0d want 0 0", a_dd, a_rd_addr);
    end
    checks++;
    if ({b_req_rdy, b_rd_en, b_rd_ce, b_dv, b_busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl_b: got %b want 00000", {b_req_rdy, b_rd_en, b_rd_ce, b_dv, b_busy});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_req_rdy !== 1'b1 || b_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b%b want 11", a_req_rdy, b_req_rdy);
    end
  endtask

  task automatic test_basic();
    int beats = 0;
    int first_k = -1;
    int last_k = -1;
    a_dr = 1'b1;
    req_a(5, 3);
    checks++;
    if (a_busy !== 1'b1 || a_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy %b ready %b want 1 0", a_busy, a_req_rdy);
    end
    for (int k = 0; k < 12; k++) begin
      if (a_dv) begin
        if (first_k < 0) first_k = k;
        checks++;
        if (a_dd !== DW'(5 + beats)) begin
          errors++;
          $display("FAIL basic_data: beat %0d got %0d want %0d", beats, a_dd, 5 + beats);
        end
        checks++;
        if (a_dl !== (beats == 3)) begin
          errors++;
          $display("FAIL basic_last: beat %0d got %b want %b", beats, a_dl, beats == 3);
        end
        if (a_dl) last_k = k;
        beats++;
      end
      if (last_k >= 0 && k == last_k + 1) begin
        checks++;
        if (a_busy !== 1'b0) begin
          errors++;
          $display("FAIL basic_busy_fall: got %b want 0", a_busy);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (beats != 4 || first_k != 3 || last_k != 6) begin
      errors++;
      $display("FAIL basic_timing: beats %0d first %0d last %0d want 4 3 6", beats, first_k, last_k);
    end
  endtask

  task automatic test_wrap();
    int exp_addr [4] = '{998, 999, 0, 1};
    int issues = 0;
    int beats = 0;
    a_dr = 1'b1;
    req_a(998, 3);
    for (int k = 0; k < 12; k++) begin
      if (a_rd_en) begin
        if (issues < 4) begin
          checks++;
          if (int'(a_rd_addr) != exp_addr[issues]) begin
            errors++;
            $display("FAIL wrap_addr: issue %0d got %0d want %0d", issues, a_rd_addr, exp_addr[issues]);
          end
        end
        issues++;
      end
      if (a_dv) begin
        if (beats < 4) begin
          checks++;
          if (a_dd !== DW'(exp_addr[beats])) begin
            errors++;
            $display("FAIL wrap_data: beat %0d got %0d want %0d", beats, a_dd, exp_addr[beats]);
          end
        end
        beats++;
      end
      @(negedge clk);
    end
    checks++;
    if (issues != 4 || beats != 4) begin
      errors++;
      $display("FAIL wrap_count: issues %0d beats %0d want 4 4", issues, beats);
    end
  endtask

  task automatic test_backpressure();
    int issues = 0;
    int beats = 0;
    a_dr = 1'b0;
    req_a(100, 15);
    for (int k = 0; k < 20; k++) begin
      if (a_rd_en) issues++;
      @(negedge clk);
    end
    checks++;
    if (issues != 4) begin
      errors++;
      $display("FAIL bp_stall_issues: got %0d want 4", issues);
    end
    checks++;
    if (a_dv !== 1'b1 || a_dd !== DW'(100) || a_dl !== 1'b0) begin
      errors++;
      $display("FAIL bp_head_hold: valid %b data %0d last %b want 1 100 0", a_dv, a_dd, a_dl);
    end
    a_dr = 1'b1;
    for (int k = 0; k < 60 && beats < 16; k++) begin
      if (a_rd_en) issues++;
      if (a_dv) begin
        checks++;
        if (a_dd !== DW'(100 + beats) || a_dl !== (beats == 15)) begin
          errors++;
          $display("FAIL bp_beat: beat %0d got %0d/%b want %0d/%b", beats, a_dd, a_dl, 100 + beats, beats == 15);
        end
        beats++;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (beats != 16 || issues != 16 || a_busy !== 1'b0 || a_dv !== 1'b0) begin
      errors++;
      $display("FAIL bp_totals: beats %0d issues %0d busy %b valid %b want 16 16 0 0", beats, issues, a_busy, a_dv);
    end
  endtask

  task automatic test_noreg();
    int beats = 0;
    int first_k = -1;
    b_dr       = 1'b1;
    b_req_addr = AW'(7);
    b_req_len  = '0;
    b_req_vld  = 1'b1;
    @(negedge clk);
    b_req_vld  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (b_rd_ce !== b_rd_en) begin
        errors++;
        $display("FAIL noreg_clk_en: cycle %0d clk_en %b want %b", k, b_rd_ce, b_rd_en);
      end
      if (b_dv) begin
        if (first_k < 0) first_k = k;
        checks++;
        if (b_dd !== DW'(7) || b_dl !== 1'b1) begin
          errors++;
          $display("FAIL noreg_beat: got %0d/%b want 7/1", b_dd, b_dl);
        end
        beats++;
      end
      @(negedge clk);
    end
    checks++;
    if (beats != 1 || first_k != 2 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL noreg_timing: beats %0d first %0d busy %b want 1 2 0", beats, first_k, b_busy);
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    a_dr = 1'b1;
    req_a(200, 7);
    for (int k = 0; k < 12; k++) begin
      if (a_dv) begin
        beats++;
        if (beats == 3) break;
      end
      @(negedge clk);
    end
    checks++;
    if (beats != 3 || a_dd !== DW'(202)) begin
      errors++;
      $display("FAIL rstmid_reach: beats %0d data %0d want 3 202", beats, a_dd);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({a_req_rdy, a_rd_en, a_rd_ce, a_rd_oce, a_dv, a_dl, a_busy} !== 7'b0 || a_dd !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: ctrl %b data %0d want 0000000 0",
               {a_req_rdy, a_rd_en, a_rd_ce, a_rd_oce, a_dv, a_dl, a_busy}, a_dd);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_req_rdy !== 1'b1 || a_busy !== 1'b0 || a_dv !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: ready %b busy %b valid %b want 1 0 0", a_req_rdy, a_busy, a_dv);
    end
    beats = 0;
    req_a(300, 1);
    for (int k = 0; k < 12; k++) begin
      if (a_dv) begin
        checks++;
        if (a_dd !== DW'(300 + beats) || a_dl !== (beats == 1)) begin
          errors++;
          $display("FAIL rstmid_new_beat: beat %0d got %0d/%b want %0d/%b", beats, a_dd, a_dl, 300 + beats, beats == 1);
        end
        beats++;
      end
      @(negedge clk);
    end
    checks++;
    if (beats != 2) begin
      errors++;
      $display("FAIL rstmid_new_count: got %0d want 2", beats);
    end
  endtask

`ifdef PDP_BURST_READER_ECC_STATUS_EN
  task automatic test_ecc();
    int beats = 0;
    ecc1_addr = 51;
    a_dr = 1'b1;
    req_a(50, 3);
    for (int k = 0; k < 12; k++) begin
      if (a_dv) begin
        checks++;
        if (a_e1 !== (beats == 1) || a_e2 !== 1'b0 || a_dd !== DW'(50 + beats)) begin
          errors++;
          $display("FAIL ecc_beat: beat %0d err1 %b err2 %b data %0d want %b 0 %0d",
                   beats, a_e1, a_e2, a_dd, beats == 1, 50 + beats);
        end
        beats++;
      end
      @(negedge clk);
    end
    ecc1_addr = -1;
    checks++;
    if (beats != 4 || a_c1 !== 16'd1 || a_c2 !== 16'd0) begin
      errors++;
      $display("FAIL ecc_counts: beats %0d one %0d two %0d want 4 1 0", beats, a_c1, a_c2);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
    a_req_vld = 1'b0; a_req_addr = '0; a_req_len = '0; a_dr = 1'b0;
    b_req_vld = 1'b0; b_req_addr = '0; b_req_len = '0; b_dr = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_noreg();
    test_reset_mid();
`ifdef PDP_BURST_READER_ECC_STATUS_EN
    test_ecc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pdp_burst_reader.md
Name: pdp_burst_reader

Overview:
- Read-side engine for the pseudo-dual-port RAM; the consumer counterpart to the PDP test master, which drives the write side.
- Accepts burst read requests (start address, beat count) on a valid/ready port.
- Drives the RAM read port (rd_en/rd_addr/clock enables) and absorbs the fixed 1- or 2-cycle RAM read latency.
- Returns data on a back-pressurable valid/ready stream, using credit-based flow control so no beat is ever dropped.

Parameters:
- RADDR_DEPTH, 1024, number of read words.
- RADDR_WIDTH, clog2(RADDR_DEPTH), read address width.
- RDATA_WIDTH, 18, read data width.
- REGMODE, "reg", "reg" = RAM output registered (latency 2); "noreg" = latency 1.
- LEN_WIDTH, 8, burst length field width; encoded as beats-1.
- FIFO_DEPTH, 4, return buffer entries; must be >= latency+1; elaboration $error otherwise.

Ports:
- rd_clk_i  in  1  read clock; all logic is on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  burst request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_addr_i  in  RADDR_WIDTH  burst start address.
- req_len_i  in  LEN_WIDTH  beats-1.
- rd_en_o  out  1  RAM read enable.
- rd_addr_o  out  RADDR_WIDTH  RAM read address.
- rd_clk_en_o  out  1  RAM read clock enable.
- rd_out_clk_en_o  out  1  RAM output register clock enable.
- rd_data_i  in  RDATA_WIDTH  RAM read data.
- one_err_det_i  in  1  RAM ECC single-bit error; used only with the macro.
- two_err_det_i  in  1  RAM ECC double-bit error; used only with the macro.
- dout_valid_o  out  1  return beat valid.
- dout_data_o  out  RDATA_WIDTH  return data.
- dout_last_o  out  1  final beat of the burst.
- dout_ready_i  in  1  consumer ready.
- busy_o  out  1  burst in progress.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM in IDLE; FIFO empty; latency pipe cleared; counters 0.
- LAT = 2 if REGMODE=="reg", else 1.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: req_ready_o=1. On accept, latch addr into rd_addr_o and len into remaining count, then go to ISSUE.
  - ISSUE: rd_en_o=1 in a cycle iff credit is available, where credit = (in_flight + fifo_count) < FIFO_DEPTH.
    - Each issue increments rd_addr_o the next cycle; RADDR_DEPTH-1 wraps to 0; non-power-of-2 depths wrap explicitly, not by truncation.
    - Each issue decrements the remaining count.
    - The final issue (remaining==0) tags the beat as last, deasserts rd_en_o next cycle, and moves to DRAIN.
  - DRAIN: wait until the last-tagged beat is popped (dout_valid_o & dout_ready_i & dout_last_o), then go to IDLE. req_ready_o=0.
- busy_o = (state != IDLE).
- Latency pipe:
  - Shift register of {valid,last} of depth LAT, fed by rd_en_o.
  - The stage-LAT output pushes rd_data_i and the last tag into the FIFO.
  - in_flight = popcount of the pipe valids.
- Clock enables:
  - rd_out_clk_en_o = rd_en_o | pipe stage-1 valid.
  - rd_clk_en_o = rd_out_clk_en_o when REGMODE=="reg", else rd_en_o.
- FIFO behaviour:
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Push is never refused; the credit rule guarantees room.
  - dout_* are driven from the FIFO head.
  - The dout_valid_o/dout_data_o pair holds stable until accepted.
- Burst length: req_len_i=0 gives 1 beat; all-ones gives 2^LEN_WIDTH beats.
- Throughput: with dout_ready_i held at 1, the block returns 1 beat per cycle. First data appears LAT+1 cycles after the accept cycle.
- Reset mid-burst: FSM, pipe and FIFO are discarded immediately. No last beat is emitted for the aborted burst.

Optional Feature:
- Macro: PDP_BURST_READER_ECC_STATUS_EN.
- With the macro:
  - one_err_det_i/two_err_det_i are sampled with the pipe stage-LAT valid and carried through the FIFO as extra bits.
  - Extra outputs: dout_err1_o and dout_err2_o, aligned with dout_data_o.
  - Extra outputs: ecc_one_cnt_o and ecc_two_cnt_o, 16-bit saturating counts of popped beats carrying each error.
  - Both counts clear only on reset.
- Without the macro: the ECC inputs are unused, the extra ports are absent, and the FIFO width is RDATA_WIDTH+1.

Decomposition:
- Package pdp_pkg:
  - clog2 function.
  - Read-latency function of REGMODE.
  - FSM state enum (IDLE/ISSUE/DRAIN).
  - Saturating counter width constant.
- Sub-module pdp_rd_fifo:
  - Synchronous FIFO, parameterized width/depth, with count output.
  - Async reset.
  - Simultaneous push/pop supported.

Test Plan:
- REGMODE="reg", RAM preloaded mem[i]=i, request addr=5 len=3, dout_ready_i=1 -> beats 5,6,7,8; last on the 4th beat; first beat 3 cycles after accept; busy_o falls the cycle after the last pop.
- RADDR_DEPTH=1000, addr=998 len=3 -> rd_addr_o sequence 998,999,0,1; data matches mem.
- dout_ready_i=0 throughout a 16-beat burst, FIFO_DEPTH=4 -> rd_en_o stops after 4 issues. Then ready=1 -> all 16 beats arrive in order, none lost or duplicated.
- REGMODE="noreg", len=0 -> single beat with last=1; latency 2 cycles from accept; rd_clk_en_o==rd_en_o.
- Assert rst_i during beat 3 of an 8-beat burst -> all outputs 0 asynchronously; after release, req_ready_o=1 and a new burst completes correctly.
- Macro defined, inject one_err_det_i on beat 2 -> dout_err1_o=1 on beat 2 only; ecc_one_cnt_o=1.
